wb_trace_buffer: RTL
====================

# wb_trace_buffer

Debug capture stage downstream of the processor/regfile pair. It snoops every register-file writeback (write enable, destination register, write data, current PC) and stores qualifying events in an on-chip FIFO. A test host or logic analyser drains the FIFO through a valid/ready port. Capture start is selectable: immediately on arm, or on a PC trigger match. The block runs on the same clock as the processor, so each writeback is sampled exactly once.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- STOP_ON_FULL, 1: 1 = capture ends when the FIFO fills; 0 = keep capturing and count drops.
- clock  in  1  processor clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it forces every register to its reset value immediately.
- arm  in  1  single-cycle request to start a capture session.
- stop  in  1  single-cycle request to end capture.
- clear  in  1  synchronous flush of FIFO, drop counter, and FSM.
- trig_en  in  1  1 = wait for a PC match before capturing.
- trig_pc  in  12  PC trigger value.
- pc  in  12  current processor PC.
- we  in  1  regfile write enable.
- wr_reg  in  5  regfile destination.
- wr_data  in  32  regfile write data.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_pc / out_reg / out_data  out  12/5/32  head entry fields; all zero when the FIFO is empty.
- count  out  $clog2(DEPTH)+1  current occupancy.
- full / empty  out  1  occupancy flags.
- drop_count  out  8  saturating count of dropped events.
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

## Operation
- An event is `we=1 && wr_reg!=0`. Writes to r0 are never recorded.
- FSM transitions (one per edge). Priority on each edge is clear > stop > arm.
  - IDLE: arm goes to ARMED if trig_en=1, otherwise to CAPTURE.
  - ARMED: `pc==trig_pc` goes to CAPTURE, and an event in that same cycle is recorded.
  - CAPTURE: stop goes to IDLE. With STOP_ON_FULL=1, a push that makes count==DEPTH goes to DONE.
  - DONE: holds until arm (re-enters as from IDLE) or clear.
  - stop in ARMED goes to IDLE. stop in DONE goes to IDLE.
  - arm in ARMED/CAPTURE is ignored.
- Recording happens when `(state==CAPTURE || (state==ARMED && pc==trig_pc)) && event`. Each record pushes the entry {pc, wr_reg, wr_data}.
- Pop happens when `out_valid && out_ready`.
- Push while full:
  - If a pop happens in the same cycle, the push is accepted and count is unchanged.
  - Otherwise the event is dropped and drop_count increments, saturating at 255.
  - With STOP_ON_FULL=1 no push is attempted in DONE, so no drop is counted there.
- Push and pop on an empty FIFO in the same cycle: the push is accepted and the pop is not possible (out_valid=0). count becomes 1.
- Pointers wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- clear: the read pointer, write pointer, count and drop_count go to 0 and the state goes to IDLE. Any push or pop in that cycle is discarded.
- Arming does not flush the FIFO; old entries remain ahead of new ones.

## Timing
- Reset values:
  - state=IDLE, count=0, empty=1, full=0, drop_count=0.
  - out_valid=0; out_pc, out_reg and out_data are 0.
- Capture latency: an event sampled at edge N is visible on the out_* fields, with out_valid=1, after edge N when the FIFO was empty before it.
- out_* fields, out_valid, full and empty are combinational from the registered pointers and storage. They do not depend combinationally on out_ready.
- A pop at edge N presents the next entry, or zeros, after edge N.
- The trigger compare is combinational in the ARMED cycle. The state shows CAPTURE from the following cycle.
- Reset asserted mid-session: outputs drop to reset values asynchronously. Operation resumes from IDLE at the first edge after deassertion.

## Test plan
- Reset/idle: assert reset, then pulse we=1, wr_reg=3 for 5 cycles with no arm -> count=0, out_valid=0, state=0, all out_* fields are 0.
- Immediate capture: trig_en=0, arm, then writes (pc=0x004,r1,0xA), (pc=0x008,r0,0xB), (pc=0x00C,r2,0xC), out_ready=0 -> count=2, r0 write skipped. Then out_ready=1 -> head (0x004,1,0xA) and then (0x00C,2,0xC); count returns to 0.
- PC trigger: trig_en=1, trig_pc=0x010, arm, then writes at pc 0x008 and 0x00C, then r5=0x55 at pc 0x010 -> state goes 1 then 2. The first entry is (0x010,5,0x55); count=1.
- Fill and stop, DEPTH=16, STOP_ON_FULL=1, out_ready=0: 20 events -> after the 16th, full=1 and state=DONE. drop_count=0. Entries read back in order.
- Drop counting, STOP_ON_FULL=0, out_ready=0: 16+300 events -> drop_count=255 (saturated), count=16. Then pulse clear -> count=0, drop_count=0, state=IDLE.
- Full with simultaneous push and pop: with the FIFO full and out_ready=1, apply an event each cycle for 10 cycles -> count stays 16, drop_count=0, output order preserved.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: snoops register-file writebacks and stores qualifying
// events ({pc, wr_reg, wr_data}) in a FIFO, drained through a valid/ready port.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   arm_i, stop_i, clear_i        session control (priority clear > stop > arm)
//   trig_en_i, trig_pc_i          optional PC trigger before capture starts
//   pc_i, we_i, wr_reg_i, wr_data_i  snooped writeback
//   out_valid_o, out_ready_i      drain handshake
//   out_pc_o/out_reg_o/out_data_o head entry, zero when empty
//   count_o, full_o, empty_o      occupancy
//   drop_count_o                  saturating count of dropped events
//   state_o                       IDLE=0 ARMED=1 CAPTURE=2 DONE=3
module wb_trace_buffer #(
  parameter int unsigned DEPTH        = 16,
  parameter bit          STOP_ON_FULL = 1'b1,
  localparam int unsigned AW          = $clog2(DEPTH),
  localparam int unsigned CW          = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          arm_i,
  input  logic          stop_i,
  input  logic          clear_i,
  input  logic          trig_en_i,
  input  logic [11:0]   trig_pc_i,
  input  logic [11:0]   pc_i,
  input  logic          we_i,
  input  logic [4:0]    wr_reg_i,
  input  logic [31:0]   wr_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [11:0]   out_pc_o,
  output logic [4:0]    out_reg_o,
  output logic [31:0]   out_data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [7:0]    drop_count_o,
  output logic [1:0]    state_o
);

  localparam int unsigned EW = 49;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      drop_q, drop_d;
  logic [EW-1:0]   mem_q [DEPTH];

  logic            event_c, match_c, rec_c, full_c, pop_c, push_c;
  logic [EW-1:0]   head_c;

  // Event qualification; a push into a full FIFO is only legal alongside a pop.
  assign event_c = we_i && (wr_reg_i != 5'd0);
  assign match_c = (pc_i == trig_pc_i);
  assign rec_c   = event_c && ((state_q == CAPTURE) || ((state_q == ARMED) && match_c));
  assign full_c  = (cnt_q == CW'(DEPTH));
  assign pop_c   = (cnt_q != '0) && out_ready_i;
  assign push_c  = rec_c && (!full_c || pop_c);

  // Next-state for FSM, pointers, occupancy and drop counter.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;

    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (push_c && !pop_c)      cnt_d = cnt_q + CW'(1);
    else if (pop_c && !push_c) cnt_d = cnt_q - CW'(1);

    if (rec_c && !push_c && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

    if (stop_i) begin
      state_d = IDLE;
    end else if (arm_i && ((state_q == IDLE) || (state_q == DONE))) begin
      state_d = trig_en_i ? ARMED : CAPTURE;
    end else if ((state_q == ARMED) && match_c) begin
      state_d = CAPTURE;
    end else if ((state_q == CAPTURE) && STOP_ON_FULL && push_c && (cnt_d == CW'(DEPTH))) begin
      state_d = DONE;
    end

    if (clear_i) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      drop_d   = '0;
    end
  end

  // Control registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  // Entry storage; contents are only observable through a valid head.
  always_ff @(posedge clk_i) begin
    if (push_c && !clear_i) mem_q[wr_ptr_q] <= {pc_i, wr_reg_i, wr_data_i};
  end

  assign head_c       = mem_q[rd_ptr_q];
  assign out_valid_o  = (cnt_q != '0);
  assign out_pc_o     = out_valid_o ? head_c[48:37] : 12'd0;
  assign out_reg_o    = out_valid_o ? head_c[36:32] : 5'd0;
  assign out_data_o   = out_valid_o ? head_c[31:0]  : 32'd0;
  assign count_o      = cnt_q;
  assign full_o       = full_c;
  assign empty_o      = (cnt_q == '0);
  assign drop_count_o = drop_q;
  assign state_o      = state_q;

endmodule
